// File: rtl/wb_copy_dma.sv
// Wishbone classic copy engine: reads one word, writes it, repeats.
// A single word buffer keeps it strictly read-then-write. An idle cycle
// separates every bus access. A per-access ack timeout aborts the copy and
// sets a sticky error flag.
module wb_copy_dma #(
  parameter int AW      = 30,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [LW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [3:0]    be_o,
  output logic [AW-1:0] adr_o,
  output logic [31:0]   dat_o,
  input  logic [31:0]   dat_i,
  input  logic          ack_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic [LW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          tmo;

  // The last no-ack cycle allowed for the current access.
  assign tmo   = (tcnt == TW'(TIMEOUT - 1));
  // Strobe and byte enables follow the registered cycle flag.
  assign stb_o = cyc_o;
  assign be_o  = cyc_o ? 4'hF : 4'h0;

  // Copy sequencer; all bus and status outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      cyc_o   <= 1'b0;
      we_o    <= 1'b0;
      adr_o   <= '0;
      dat_o   <= '0;
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      tcnt    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            src_ptr <= src_i;
            dst_ptr <= dst_i;
            cnt     <= len_i;
            err_o   <= 1'b0;
            tcnt    <= '0;
            if (len_i == '0) begin
              // Empty copy: report completion without touching the bus.
              state <= S_DONE;
            end else begin
              state  <= S_RD;
              busy_o <= 1'b1;
              cyc_o  <= 1'b1;
              we_o   <= 1'b0;
              adr_o  <= src_i;
            end
          end
        end
        S_RD: begin
          if (ack_i) begin
            dat_o   <= dat_i;
            src_ptr <= src_ptr + AW'(1);
            cyc_o   <= 1'b0;
            state   <= S_RGAP;
          end else if (tmo) begin
            cyc_o <= 1'b0;
            err_o <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_RGAP: begin
          state <= S_WR;
          cyc_o <= 1'b1;
          we_o  <= 1'b1;
          adr_o <= dst_ptr;
          tcnt  <= '0;
        end
        S_WR: begin
          if (ack_i) begin
            dst_ptr <= dst_ptr + AW'(1);
            cnt     <= cnt - LW'(1);
            cyc_o   <= 1'b0;
            we_o    <= 1'b0;
            state   <= S_WGAP;
          end else if (tmo) begin
            cyc_o <= 1'b0;
            we_o  <= 1'b0;
            err_o <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WGAP: begin
          if (cnt == '0) begin
            state <= S_DONE;
          end else begin
            state <= S_RD;
            cyc_o <= 1'b1;
            adr_o <= src_ptr;
            tcnt  <= '0;
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_dma.sv
// Directed plus randomized bench for wb_copy_dma (AW=8, TIMEOUT=8) with a
// RAM responder, a bus monitor and a word-by-word copy reference model.
module tb_wb_copy_dma;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  src_i = '0, dst_i = '0, len_i = '0;
  logic        busy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [3:0]  be_o;
  logic [7:0]  adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  wb_copy_dma #(.AW(8), .LW(8), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .start_i(start_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .be_o(be_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  // RAM responder: registered ack after wait_n extra cycles; preload port.
  logic [31:0] mem [256];
  int          wait_n = 0;
  bit          nack_wr = 1'b0;
  int          wcnt = 0;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_adr = '0;
  logic [31:0] pl_dat = '0;

  always @(posedge clk_i) begin
    if (pl_we) mem[pl_adr] <= pl_dat;
    if (!rst_in) begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end else if (cyc_o && stb_o && !ack_i) begin
      if (wcnt >= wait_n && !(we_o && nack_wr)) begin
        ack_i <= 1'b1;
        wcnt  <= 0;
        if (we_o) mem[adr_o] <= dat_o;
        else      dat_i <= mem[adr_o];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack_i <= 1'b0;
      wcnt  <= 0;
    end
  end

  // Bus monitor: protocol statistics and acked-transfer log.
  int          busy_cyc = 0, done_cnt = 0, cyc_cyc = 0;
  int          strobe_viol = 0, dat_viol = 0, gap_viol = 0;
  int          gap_len = 0, cur_run = 0, last_wr_run = 0;
  bit          in_gap = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_dat = '0;
  logic [40:0] log_q [$];

  always @(negedge clk_i) begin
    if (stb_o !== cyc_o || be_o !== (cyc_o ? 4'hF : 4'h0)) strobe_viol <= strobe_viol + 1;
    if (busy_o) busy_cyc <= busy_cyc + 1;
    if (done_o) done_cnt <= done_cnt + 1;
    if (cyc_o)  cyc_cyc  <= cyc_cyc + 1;
    if (cyc_o && we_o && prev_wr && dat_o !== prev_dat) dat_viol <= dat_viol + 1;
    prev_wr  <= cyc_o && we_o;
    prev_dat <= dat_o;
    if (cyc_o && ack_i) log_q.push_back({we_o, adr_o, we_o ? dat_o : dat_i});
    if (!busy_o) begin
      in_gap  <= 1'b0;
      gap_len <= 0;
    end else if (cyc_o) begin
      if (in_gap && gap_len != 1) gap_viol <= gap_viol + 1;
      in_gap  <= 1'b0;
      gap_len <= 0;
    end else begin
      in_gap  <= 1'b1;
      gap_len <= gap_len + 1;
    end
    if (cyc_o && we_o) cur_run <= cur_run + 1;
    else if (cur_run != 0) begin
      last_wr_run <= cur_run;
      cur_run     <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first cycle after acceptance.
  task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
    @(negedge clk_i);
    start_i = 1'b1; src_i = s; dst_i = d; len_i = n;
    @(negedge clk_i);
    start_i = 1'b0;
    src_i = 8'($urandom); dst_i = 8'($urandom); len_i = 8'($urandom);
  endtask

  task automatic wait_done(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (done_o) begin ok = 1'b1; break; end
      @(negedge clk_i);
    end
    chk("done_seen", 64'(ok), 64'd1);
  endtask

  // Full copy against a word-by-word forward-copy model.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input int n,
                          input int w, input bit poke);
    logic [31:0] model [256];
    logic [40:0] exp_q [$];
    logic [7:0]  sa, da;
    int lb, bb, db, gb, vb, bad;
    wait_n = w;
    for (int i = 0; i < 256; i++) model[i] = mem[i];
    for (int i = 0; i < n; i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      exp_q.push_back({1'b0, sa, model[sa]});
      exp_q.push_back({1'b1, da, model[sa]});
      model[da] = model[sa];
    end
    lb = log_q.size(); bb = busy_cyc; db = done_cnt; gb = gap_viol;
    vb = strobe_viol + dat_viol;
    do_start(s, d, 8'(n));
    chk("busy_after_start", 64'(busy_o), 64'd1);
    chk("err_cleared", 64'(err_o), 64'd0);
    chk("cyc_after_start", 64'(cyc_o), 64'd1);
    if (poke) begin
      repeat (4) @(negedge clk_i);
      start_i = 1'b1; src_i = s + 8'd100; dst_i = d + 8'd7; len_i = 8'd1;
      @(negedge clk_i);
      start_i = 1'b0;
    end
    wait_done(2000);
    repeat (2) @(negedge clk_i);
    chk("done_pulses", 64'(done_cnt - db), 64'd1);
    chk("err_after_copy", 64'(err_o), 64'd0);
    chk("busy_cycles", 64'(busy_cyc - bb), 64'(n * (6 + 2 * w) + 1));
    chk("gap_violations", 64'(gap_viol - gb), 64'd0);
    chk("strobe_dat_violations", 64'(strobe_viol + dat_viol - vb), 64'd0);
    chk("log_len", 64'(log_q.size() - lb), 64'(2 * n));
    bad = 0;
    if (log_q.size() - lb == 2 * n) begin
      for (int i = 0; i < 2 * n; i++) if (log_q[lb + i] !== exp_q[i]) bad++;
    end else bad = 2 * n;
    chk("log_seq", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model[i]) bad++;
    chk("mem_image", 64'(bad), 64'd0);
  endtask

  initial begin
    int db, bb, cb, lb;
    logic [31:0] old;
    bit seen;

    // Reset state.
    #2 rst_in = 1'b0;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err",  64'(err_o),  64'd0);
    chk("rst_cyc",  64'(cyc_o),  64'd0);
    chk("rst_stb",  64'(stb_o),  64'd0);
    chk("rst_we",   64'(we_o),   64'd0);
    chk("rst_be",   64'(be_o),   64'd0);
    chk("rst_adr",  64'(adr_o),  64'd0);
    chk("rst_dat",  64'(dat_o),  64'd0);
    repeat (2) @(negedge clk_i);
    rst_in = 1'b1;

    // Preload memory with random words, then the basic-copy pattern.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_i);
      pl_we = 1'b1; pl_adr = 8'(i);
      pl_dat = (i >= 16 && i < 20) ? 32'hA000_0000 + 32'(i - 16) : $urandom;
    end
    @(negedge clk_i);
    pl_we = 1'b0;

    // Basic copy.
    run_copy(8'h10, 8'h40, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("basic_word", 64'(mem[8'h40 + 8'(i)]), 64'(32'hA000_0000 + 32'(i)));

    // Zero length.
    db = done_cnt; bb = busy_cyc; cb = cyc_cyc;
    do_start(8'h33, 8'h44, 8'd0);
    chk("zl_done_c1", 64'(done_o), 64'd0);
    @(negedge clk_i);
    chk("zl_done_c2", 64'(done_o), 64'd1);
    repeat (2) @(negedge clk_i);
    chk("zl_done_count", 64'(done_cnt - db), 64'd1);
    chk("zl_busy", 64'(busy_cyc - bb), 64'd0);
    chk("zl_cyc", 64'(cyc_cyc - cb), 64'd0);

    // Address wrap.
    run_copy(8'hFF, 8'hFE, 2, 0, 1'b0);

    // Ignored start while busy, with three wait states per access.
    run_copy(8'h20, 8'h80, 5, 3, 1'b1);

    // Timeout on writes.
    nack_wr = 1'b1; wait_n = 0;
    old = mem[8'h60];
    db = done_cnt; bb = busy_cyc; lb = log_q.size();
    do_start(8'h50, 8'h60, 8'd3);
    wait_done(200);
    repeat (2) @(negedge clk_i);
    chk("tmo_wr_hold", 64'(last_wr_run), 64'd8);
    chk("tmo_err", 64'(err_o), 64'd1);
    chk("tmo_done_count", 64'(done_cnt - db), 64'd1);
    chk("tmo_busy", 64'(busy_cyc - bb), 64'd12);
    chk("tmo_log_len", 64'(log_q.size() - lb), 64'd1);
    chk("tmo_dst_untouched", 64'(mem[8'h60]), 64'(old));
    nack_wr = 1'b0;
    run_copy(8'h30, 8'h90, 2, 0, 1'b0);

    // Reset during a write.
    wait_n = 3;
    do_start(8'h70, 8'hA0, 8'd4);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cyc_o && we_o) begin seen = 1'b1; break; end
      @(negedge clk_i);
    end
    chk("mid_wr_seen", 64'(seen), 64'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_cyc",  64'(cyc_o),  64'd0);
    chk("mid_rst_stb",  64'(stb_o),  64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_we",   64'(we_o),   64'd0);
    chk("mid_rst_be",   64'(be_o),   64'd0);
    chk("mid_rst_adr",  64'(adr_o),  64'd0);
    chk("mid_rst_dat",  64'(dat_o),  64'd0);
    @(negedge clk_i);
    rst_in = 1'b1;
    @(negedge clk_i);
    run_copy(8'h70, 8'hA0, 4, 0, 1'b0);

    // Random copies.
    for (int k = 0; k < 4; k++)
      run_copy(8'($urandom), 8'($urandom), int'($urandom_range(1, 6)),
               int'($urandom_range(0, 2)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
